// File: rtl/pipo_arb_pkg.sv
// Shared definitions for the PIPO load arbiter: FSM state encoding
// and the width of the HOLD down-counter.
package pipo_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   // Wide enough for HOLD_CYC-1 with HOLD_CYC up to 15.
   localparam int unsigned CNT_W = 4;

   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/pipo_load_arbiter_rr_pick.sv
// Round-robin winner search: scans upward from last_winner+1 with
// wrap-around and reports the first active requester.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_winner,
   output logic [IDX_W-1:0] winner,
   output logic             valid
);

   // Walk the search order backwards so the nearest hit is written last.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int k = N_REQ; k >= 1; k--) begin
         if (req[(int'(last_winner) + k) % N_REQ]) begin
            winner = IDX_W'((int'(last_winner) + k) % N_REQ);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter granting one requester at a time the right to
// load a shared PIPO register, which is then presented for HOLD_CYC cycles.
module pipo_load_arbiter
   import pipo_arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = 33,
   parameter int HOLD_CYC = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   data_in,
   output logic [N_REQ-1:0]         gnt,
   output logic [WIDTH-1:0]         q,
   output logic                     q_valid,
   output logic [$clog2(N_REQ)-1:0] q_src,
   output logic                     busy
);

   localparam int IDX_W = $clog2(N_REQ);

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [IDX_W-1:0]   win_q, win_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [IDX_W-1:0]   src_q, src_d;
   logic               vld_q, vld_d;
   logic               busy_q, busy_d;
   cnt_t               cnt_q, cnt_d;

   logic [IDX_W-1:0]   pick;
   logic               pick_vld;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req         (req),
      .last_winner (last_q),
      .winner      (pick),
      .valid       (pick_vld)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      win_d   = win_q;
      last_d  = last_q;
      q_d     = q_q;
      src_d   = src_q;
      vld_d   = vld_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_d     = ST_GRANT;
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
               win_d       = pick;
               busy_d      = 1'b1;
            end
         end
         ST_GRANT: begin
            gnt_d = '0;
            // The winner must still be asking at the closing edge to load.
            if (req[win_q]) begin
               state_d = ST_HOLD;
               q_d     = data_in[win_q*WIDTH +: WIDTH];
               src_d   = win_q;
               last_d  = win_q;
               vld_d   = 1'b1;
               cnt_d   = cnt_t'(HOLD_CYC - 1);
            end else begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               vld_d   = 1'b0;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // Last winner resets to N_REQ-1 so requester 0 is searched first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         win_q   <= '0;
         last_q  <= IDX_W'(N_REQ - 1);
         q_q     <= '0;
         src_q   <= '0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         win_q   <= win_d;
         last_q  <= last_d;
         q_q     <= q_d;
         src_q   <= src_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt     = gnt_q;
   assign q       = q_q;
   assign q_valid = vld_q;
   assign q_src   = src_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Scoreboard bench: expected loads (source, data, cycle) are queued when
// stimulus is driven and popped when q_valid rises.
module tb_pipo_load_arbiter;

   localparam int N = 4;
   localparam int W = 33;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req0 = '0;
   logic [N-1:0]   req1 = '0;
   logic [N*W-1:0] din0 = '0;
   logic [N*W-1:0] din1 = '0;

   logic [N-1:0]   gnt0, gnt1;
   logic [W-1:0]   q0, q1;
   logic           qv0, qv1;
   logic [1:0]     src0, src1;
   logic           busy0, busy1;

   pipo_load_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYC(2)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req0),
      .data_in (din0),
      .gnt     (gnt0),
      .q       (q0),
      .q_valid (qv0),
      .q_src   (src0),
      .busy    (busy0)
   );

   pipo_load_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYC(1)) u_dut1 (
      .clk     (clk),
      .rst     (rst),
      .req     (req1),
      .data_in (din1),
      .gnt     (gnt1),
      .q       (q1),
      .q_valid (qv1),
      .q_src   (src1),
      .busy    (busy1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, cyc);
      end
   endtask

   typedef struct {
      int           src;
      logic [W-1:0] data;
      int           at;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];
   exp_t e0, e1;
   logic pv0 = 1'b0;
   logic pv1 = 1'b0;

   function automatic exp_t mk(input int s, input logic [W-1:0] d, input int t);
      exp_t e;
      e.src  = s;
      e.data = d;
      e.at   = t;
      return e;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic setd0(input int i, input logic [W-1:0] v);
      din0[i*W +: W] = v;
   endtask

   task automatic setd1(input int i, input logic [W-1:0] v);
      din1[i*W +: W] = v;
   endtask

   always @(negedge clk) begin
      if (qv0 && !pv0) begin
         if (sb0.size() == 0) begin
            chk("unexp_load0", 64'd1, 64'd0);
         end else begin
            e0 = sb0.pop_front();
            chk("q0", 64'(q0), 64'(e0.data));
            chk("src0", 64'(src0), 64'(e0.src));
            chk("t0", 64'(cyc), 64'(e0.at));
         end
      end
      pv0 = qv0;
      if (qv1 && !pv1) begin
         if (sb1.size() == 0) begin
            chk("unexp_load1", 64'd1, 64'd0);
         end else begin
            e1 = sb1.pop_front();
            chk("q1", 64'(q1), 64'(e1.data));
            chk("src1", 64'(src1), 64'(e1.src));
            chk("t1", 64'(cyc), 64'(e1.at));
         end
      end
      pv1 = qv1;
   end

   initial begin
      int c;
      // reset values
      tick(2);
      chk("rst_gnt", 64'(gnt0), 64'd0);
      chk("rst_q", 64'(q0), 64'd0);
      chk("rst_qv", 64'(qv0), 64'd0);
      chk("rst_src", 64'(src0), 64'd0);
      chk("rst_busy", 64'(busy0), 64'd0);
      rst = 1'b0;

      // single requester 0, data 15
      c = cyc;
      req0 = 4'b0001;
      setd0(0, 33'd15);
      sb0.push_back(mk(0, 33'd15, c + 2));
      tick(1);
      chk("t1_gnt", 64'(gnt0), 64'b0001);
      chk("t1_busy", 64'(busy0), 64'd1);
      chk("t1_qv_grant", 64'(qv0), 64'd0);
      tick(1);
      chk("t1_gnt_clr", 64'(gnt0), 64'd0);
      chk("t1_qv_a", 64'(qv0), 64'd1);
      tick(1);
      chk("t1_qv_b", 64'(qv0), 64'd1);
      req0 = '0;
      tick(1);
      chk("t1_qv_end", 64'(qv0), 64'd0);
      chk("t1_idle", 64'(busy0), 64'd0);
      tick(2);
      chk("t1_q_hold", 64'(q0), 64'd15);

      // all four held: order 0,1,2,3,0 every 4 cycles
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      c = cyc;
      for (int i = 0; i < 4; i++) setd0(i, W'(i + 1));
      req0 = 4'b1111;
      for (int k = 0; k < 5; k++)
         sb0.push_back(mk(k % 4, W'(k % 4 + 1), c + 2 + 4 * k));
      tick(1);
      chk("t2_gnt0", 64'(gnt0), 64'b0001);
      tick(4);
      chk("t2_gnt1", 64'(gnt0), 64'b0010);
      tick(14);
      req0 = '0;
      tick(3);
      chk("t2_idle", 64'(busy0), 64'd0);

      // requester 2 wins, then 0101 wraps to 0
      c = cyc;
      req0 = 4'b0100;
      setd0(2, 33'd333);
      sb0.push_back(mk(2, 33'd333, c + 2));
      tick(3);
      req0 = '0;
      tick(1);
      chk("t3_idle", 64'(busy0), 64'd0);
      c = cyc;
      req0 = 4'b0101;
      setd0(0, 33'd444);
      sb0.push_back(mk(0, 33'd444, c + 2));
      tick(1);
      chk("t3_wrap_gnt", 64'(gnt0), 64'b0001);
      tick(2);
      req0 = '0;
      tick(2);

      // requester 1 withdraws during GRANT, keeps priority
      req0 = 4'b0010;
      setd0(1, 33'd555);
      tick(1);
      chk("t4_gnt", 64'(gnt0), 64'b0010);
      req0 = '0;
      tick(1);
      chk("t4_wd_busy", 64'(busy0), 64'd0);
      chk("t4_wd_qv", 64'(qv0), 64'd0);
      chk("t4_wd_q", 64'(q0), 64'd444);
      chk("t4_wd_gnt", 64'(gnt0), 64'd0);
      c = cyc;
      req0 = 4'b0110;
      setd0(2, 33'd666);
      sb0.push_back(mk(1, 33'd555, c + 2));
      tick(1);
      chk("t4_prio_gnt", 64'(gnt0), 64'b0010);
      req0 = 4'b1110;
      tick(1);
      chk("t4_gnt_clr", 64'(gnt0), 64'd0);
      req0 = '0;
      tick(3);
      chk("t4_idle", 64'(busy0), 64'd0);

      // reset during HOLD, then requester 3 first after 0
      c = cyc;
      req0 = 4'b0001;
      setd0(0, 33'd10);
      sb0.push_back(mk(0, 33'd10, c + 2));
      tick(2);
      #2;
      rst = 1'b1;
      req0 = '0;
      #1;
      chk("t5_q", 64'(q0), 64'd0);
      chk("t5_qv", 64'(qv0), 64'd0);
      chk("t5_busy", 64'(busy0), 64'd0);
      chk("t5_gnt", 64'(gnt0), 64'd0);
      tick(1);
      rst = 1'b0;
      c = cyc;
      req0 = 4'b1000;
      setd0(3, 33'd77);
      sb0.push_back(mk(3, 33'd77, c + 2));
      tick(1);
      chk("t5_gnt3", 64'(gnt0), 64'b1000);
      tick(2);
      req0 = '0;
      tick(2);

      // HOLD_CYC=1: loads every 3 cycles, 1-cycle valid
      c = cyc;
      req1 = 4'b0100;
      setd1(2, 33'd55);
      for (int k = 0; k < 3; k++)
         sb1.push_back(mk(2, 33'd55, c + 2 + 3 * k));
      tick(3);
      chk("t6_qv_low", 64'(qv1), 64'd0);
      chk("t6_idle", 64'(busy1), 64'd0);
      tick(1);
      chk("t6_gnt", 64'(gnt1), 64'b0100);
      tick(4);
      req1 = '0;
      tick(3);
      chk("t6_end_busy", 64'(busy1), 64'd0);

      tick(2);
      chk("sb0_empty", 64'(sb0.size()), 64'd0);
      chk("sb1_empty", 64'(sb1.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
